// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer/flag controller of the async FIFO: binary write address, Gray write
// pointer for the read domain, synchronised read pointer, full/almost-full/level, sticky overflow.
module fifo_wr_ctrl #(
  parameter int WIDTH     = 3,
  parameter int AF_MARGIN = 1
) (
  input  logic             w_clk,
  input  logic             w_rst,
  input  logic             w_inc,
  input  logic [WIDTH:0]   rd_ptr,
  input  logic             ovf_clr,
  output logic [WIDTH:0]   wr_ptr,
  output logic [WIDTH-1:0] w_addr,
  output logic             w_en,
  output logic             full,
  output logic             almost_full,
  output logic [WIDTH:0]   w_level,
  output logic             overflow
);

  localparam int unsigned AF_THRESH = (2 ** WIDTH) - AF_MARGIN;

  logic [WIDTH:0] wr_bin_q, wr_bin_d;
  logic [WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [WIDTH:0] rq1_q, rq2_q;
  logic           overflow_q, overflow_d;
  logic [WIDTH:0] rd_bin_sync;

  // Write enable is also held low while reset is asserted so the memory never
  // captures a word during reset, even with the producer still requesting.
  always_comb begin
    full     = (wr_ptr_q == {~rq2_q[WIDTH:WIDTH-1], rq2_q[WIDTH-2:0]});
    w_en     = w_inc & ~full & w_rst;
    wr_bin_d = wr_bin_q + {{WIDTH{1'b0}}, w_en};
    wr_ptr_d = (wr_bin_d >> 1) ^ wr_bin_d;
  end

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rd_bin_sync = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      rd_bin_sync[i] = ^(rq2_q >> i);
    end
  end

  always_comb begin
    w_level     = wr_bin_q - rd_bin_sync;
    almost_full = (32'(w_level) >= AF_THRESH);
    overflow_d  = overflow_q;
    if (w_inc && full) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) begin
      wr_bin_q   <= '0;
      wr_ptr_q   <= '0;
      rq1_q      <= '0;
      rq2_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_bin_q   <= wr_bin_d;
      wr_ptr_q   <= wr_ptr_d;
      rq1_q      <= rd_ptr;
      rq2_q      <= rq1_q;
      overflow_q <= overflow_d;
    end
  end

  assign wr_ptr   = wr_ptr_q;
  assign w_addr   = wr_bin_q[WIDTH-1:0];
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl: reset, fill, overflow, read release, wrap and
// almost-full threshold (second instance with AF_MARGIN=3 on the same stimulus).
module tb_fifo_wr_ctrl;

  localparam int WIDTH = 3;

  logic             w_clk = 1'b0;
  logic             w_rst;
  logic             w_inc;
  logic [WIDTH:0]   rd_ptr;
  logic             ovf_clr;
  logic [WIDTH:0]   wr_ptr;
  logic [WIDTH-1:0] w_addr;
  logic             w_en;
  logic             full;
  logic             almost_full;
  logic [WIDTH:0]   w_level;
  logic             overflow;

  logic [WIDTH:0]   wr_ptr3;
  logic [WIDTH-1:0] w_addr3;
  logic             w_en3;
  logic             full3;
  logic             almost_full3;
  logic [WIDTH:0]   w_level3;
  logic             overflow3;

  int tests_run    = 0;
  int tests_failed = 0;

  fifo_wr_ctrl #(.WIDTH(WIDTH), .AF_MARGIN(1)) dut (
    .w_clk(w_clk), .w_rst(w_rst), .w_inc(w_inc), .rd_ptr(rd_ptr), .ovf_clr(ovf_clr),
    .wr_ptr(wr_ptr), .w_addr(w_addr), .w_en(w_en), .full(full),
    .almost_full(almost_full), .w_level(w_level), .overflow(overflow)
  );

  fifo_wr_ctrl #(.WIDTH(WIDTH), .AF_MARGIN(3)) dut_af3 (
    .w_clk(w_clk), .w_rst(w_rst), .w_inc(w_inc), .rd_ptr(rd_ptr), .ovf_clr(ovf_clr),
    .wr_ptr(wr_ptr3), .w_addr(w_addr3), .w_en(w_en3), .full(full3),
    .almost_full(almost_full3), .w_level(w_level3), .overflow(overflow3)
  );

  // clock / reset
  always #5 w_clk = ~w_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One active edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic do_reset();
    w_rst = 1'b0;
    #2;
    w_rst = 1'b1;
  endtask

  function automatic logic [3:0] gray(input int b);
    logic [3:0] t;
    t = b[3:0];
    return t ^ (t >> 1);
  endfunction

  logic [3:0] fill_ptr [8];

  initial begin
    fill_ptr = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
    w_rst   = 1'b0;
    w_inc   = 1'b0;
    rd_ptr  = '0;
    ovf_clr = 1'b0;

    // Reset state
    #1;
    check("rst_wr_ptr", wr_ptr, 0);
    check("rst_w_addr", w_addr, 0);
    check("rst_full", full, 0);
    check("rst_level", w_level, 0);
    check("rst_af", almost_full, 0);
    check("rst_ovf", overflow, 0);
    tick();
    w_rst = 1'b1;

    // Reset asserted mid-burst with w_inc held high
    w_inc = 1'b1;
    repeat (3) tick();
    check("burst_addr", w_addr, 3);
    w_rst = 1'b0;
    #1;
    check("midrst_wr_ptr", wr_ptr, 0);
    check("midrst_w_addr", w_addr, 0);
    check("midrst_level", w_level, 0);
    check("midrst_w_en", w_en, 0);
    check("midrst_full", full, 0);
    w_rst = 1'b1;
    #1;
    check("first_addr", w_addr, 0);
    check("first_w_en", w_en, 1);
    tick();
    check("first_wr_ptr", wr_ptr, 4'b0001);
    check("first_addr_next", w_addr, 1);
    w_inc = 1'b0;
    do_reset();

    // Fill with rd_ptr=0
    w_inc = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("fill%0d_wr_ptr", k), wr_ptr, fill_ptr[k-1]);
      check($sformatf("fill%0d_level", k), w_level, k);
      check($sformatf("fill%0d_af", k), almost_full, (k >= 7));
      check($sformatf("fill%0d_af3", k), almost_full3, (k >= 5));
      check($sformatf("fill%0d_full", k), full, (k == 8));
      check($sformatf("fill%0d_full3", k), full3, (k == 8));
    end

    // Overflow: write held while full
    for (int k = 0; k < 3; k++) begin
      check("ovf_w_en", w_en, 0);
      tick();
      check("ovf_wr_ptr", wr_ptr, 4'b1100);
      check("ovf_flag", overflow, 1);
    end
    check("ovf_level", w_level, 8);
    w_inc   = 1'b0;
    ovf_clr = 1'b1;
    tick();
    check("ovf_cleared", overflow, 0);
    w_inc = 1'b1;
    tick();
    check("ovf_set_wins", overflow, 1);
    w_inc = 1'b0;
    tick();
    check("ovf_cleared2", overflow, 0);
    ovf_clr = 1'b0;

    // Read release: two-edge synchroniser lag
    rd_ptr = 4'b0001;
    tick();
    check("rel_full_e1", full, 1);
    tick();
    check("rel_full_e2", full, 0);
    check("rel_level", w_level, 7);
    check("rel_af", almost_full, 1);
    w_inc = 1'b1;
    #1;
    check("rel_w_addr", w_addr, 0);
    check("rel_w_en", w_en, 1);
    tick();
    check("rel_wr_ptr", wr_ptr, 4'b1101);
    check("rel_refull", full, 1);
    check("rel_level8", w_level, 8);
    w_inc = 1'b0;
    rd_ptr = '0;
    do_reset();

    // Wrap: rd_ptr follows the write count two behind
    w_inc = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      rd_ptr = gray((j >= 3) ? j - 3 : 0);
      tick();
      check($sformatf("wrap%0d_addr", j), w_addr, j % 8);
      check($sformatf("wrap%0d_wr_ptr", j), wr_ptr, gray(j % 16));
      check($sformatf("wrap%0d_level", j), w_level, (j < 4) ? j : 4);
      check($sformatf("wrap%0d_full", j), full, 0);
      check($sformatf("wrap%0d_af", j), almost_full, 0);
    end
    w_inc = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Write-side pointer and flag controller for the async FIFO. It pairs with the read-side controller in the other clock domain.
- Generates the binary write address and the Gray-coded write pointer handed to the read domain.
- Synchronises the Gray read pointer into the write domain and derives full, almost-full and fill level.
- Flags and holds any write attempted while the FIFO is full.
- Sits between the UART/ALU data producer and the dual-port FIFO memory.

Parameters:
- WIDTH, 3, address width; FIFO depth = 2^WIDTH entries; pointers are WIDTH+1 bits.
- AF_MARGIN, 1, almost_full asserts when fill level >= 2^WIDTH - AF_MARGIN; legal range 0..2^WIDTH-1.

Ports:
- w_clk  input  1  write-domain clock.
- w_rst  input  1  asynchronous active-low reset.
- w_inc  input  1  write request from producer.
- rd_ptr  input  WIDTH+1  Gray read pointer from read domain; asynchronous to w_clk.
- ovf_clr  input  1  clears sticky overflow.
- wr_ptr  output  WIDTH+1  registered Gray write pointer to read domain.
- w_addr  output  WIDTH  binary write address to FIFO memory.
- w_en  output  1  memory write enable.
- full  output  1  FIFO full.
- almost_full  output  1  fill level at or above threshold.
- w_level  output  WIDTH+1  write-domain fill level, 0..2^WIDTH.
- overflow  output  1  sticky write-while-full error.

Behaviour:
- One clock, w_clk. Reset is asynchronous, active-low (w_rst). On assertion, all registers clear immediately, including mid-operation:
  - wr_bin=0, wr_ptr=0, both synchroniser stages=0, overflow=0.
  - Resulting outputs: w_addr=0, full=0, w_level=0, w_en=0.
  - almost_full=0 unless AF_MARGIN=2^WIDTH (illegal).
- Write acceptance: w_en = w_inc & ~full, combinational.
  - wr_bin_next = wr_bin + w_en.
  - On each w_clk edge: wr_bin <= wr_bin_next; wr_ptr <= (wr_bin_next >> 1) ^ wr_bin_next. wr_ptr is always registered and glitch-free.
  - w_addr = wr_bin[WIDTH-1:0]. The memory captures data at w_addr on the same edge that w_en is sampled.
- Pointer wrap-around: wr_bin wraps modulo 2^(WIDTH+1). The MSB toggles each pass through the memory.
- Read-pointer synchroniser:
  - Two flops, rq1 <= rd_ptr; rq2 <= rq1.
  - A change on rd_ptr is visible in the flags after 2 w_clk edges.
  - No logic sits between rd_ptr and rq1.
- Full (combinational from registers only): full = (wr_ptr == {~rq2[WIDTH:WIDTH-1], rq2[WIDTH-2:0]}).
  - Asserts combinationally after the edge that accepts the final write.
  - Deasserts 2 edges after the read domain advances rd_ptr.
- Level: rd_bin_sync = Gray-to-binary of rq2, via an XOR prefix from the MSB. w_level = wr_bin - rd_bin_sync, modulo 2^(WIDTH+1).
  - Level is pessimistic: it may overstate occupancy by in-flight reads, never understate it.
- almost_full = (w_level >= 2^WIDTH - AF_MARGIN), combinational.
- Overflow register:
  - Set on any edge where w_inc & full.
  - Cleared on an edge where ovf_clr=1 and no set condition.
  - Set wins over a simultaneous clear.
  - A rejected write never changes wr_bin, wr_ptr or the memory.
- Boundary cases:
  - Write while full: rejected and flagged.
  - Write on the cycle full deasserts: accepted.
  - Simultaneous remote read and local write: write accepted against the stale rq2 value, which is always safe.
  - rd_ptr glitches between samples: absorbed by the synchroniser; the Gray code guarantees at most one bit changes per read.

Test Plan:
- Reset: assert w_rst mid-burst with w_inc=1 -> all outputs 0 immediately; first write after release uses w_addr=0 and gives wr_ptr=4'b0001.
- Fill (WIDTH=3, rd_ptr=0): 8 consecutive w_inc pulses ->
  - wr_ptr sequence 0001,0011,0010,0110,0111,0101,0100,1100.
  - almost_full rises after the 7th write (w_level=7); full and w_level=8 after the 8th.
- Overflow: with full=1, hold w_inc 3 cycles -> w_en=0, wr_ptr stays 1100, overflow=1. Pulse ovf_clr with w_inc=0 -> overflow=0. ovf_clr and w_inc both high while full -> overflow stays 1.
- Read release: from full, drive rd_ptr=4'b0001 -> full stays 1 for 1 edge and drops after the 2nd edge; w_level=7; next w_inc writes w_addr=0.
- Wrap: 20 writes interleaved with rd_ptr following 2 behind ->
  - wr_bin passes 15->0 and w_addr 7->0 without spurious full.
  - w_level stays within 0..4 throughout, counting the 2-edge synchroniser lag.
- Threshold: AF_MARGIN=3, rd_ptr=0 -> almost_full asserts at w_level=5 and full stays 0 until w_level=8.
